// File: rtl/display_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver with double-buffered digit word.
// Optional leading-zero suppression: define DISPLAY_LEADING_ZERO_BLANK_EN.
module display_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 1000,
  parameter int CNT_W     = 20
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [15:0] DIGITS,
  output logic [3:0]  ANODE,
  output logic [6:0]  SEG,
  output logic        FRAME_DONE
);

  // IDLE: display dark, index 0 | DRIVE: digit[idx] lit | BLANK: all dark between digits
  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [15:0]       shadow, shadow_nxt;
  logic [15:0]       active, active_nxt;
  logic              pending, pending_nxt;
  logic              start_frame, frame_nxt;
  logic [15:0]       upper;
  logic [3:0]        anode_nxt;
  logic [6:0]        seg_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt + CNT_W'(1);
    start_frame = 1'b0;
    frame_nxt   = 1'b0;
    if (!EN) begin
      state_nxt = IDLE;
      idx_nxt   = 2'd0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = DRIVE;
          idx_nxt     = 2'd0;
          cnt_nxt     = '0;
          start_frame = 1'b1;
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            cnt_nxt = '0;
            if (BLANK_CYC > 0) begin
              state_nxt = BLANK;
            end else begin
              idx_nxt     = idx + 2'd1;
              start_frame = (idx == 2'd3);
              frame_nxt   = (idx == 2'd3);
            end
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt_nxt     = '0;
            state_nxt   = DRIVE;
            idx_nxt     = idx + 2'd1;
            start_frame = (idx == 2'd3);
            frame_nxt   = (idx == 2'd3);
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A LOAD coinciding with the frame transfer bypasses the shadow straight into active.
  always_comb begin
    shadow_nxt  = LOAD ? DIGITS : shadow;
    pending_nxt = pending | LOAD;
    active_nxt  = active;
    if (start_frame) begin
      if (LOAD)         active_nxt = DIGITS;
      else if (pending) active_nxt = shadow;
      pending_nxt = 1'b0;
    end
  end

  always_comb begin
    anode_nxt = 4'b1111;
    seg_nxt   = 7'b1111111;
    upper     = active_nxt >> {idx_nxt, 2'b00};
    if (state_nxt == DRIVE) begin
      anode_nxt = ~(4'b0001 << idx_nxt);
      seg_nxt   = seg_decode(upper[3:0]);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
      if (idx_nxt != 2'd0 && upper == 16'h0000) begin
        anode_nxt = 4'b1111;
        seg_nxt   = 7'b1111111;
      end
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      shadow     <= 16'h0000;
      active     <= 16'h0000;
      pending    <= 1'b0;
      ANODE      <= 4'b1111;
      SEG        <= 7'b1111111;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      shadow     <= shadow_nxt;
      active     <= active_nxt;
      pending    <= pending_nxt;
      ANODE      <= anode_nxt;
      SEG        <= seg_nxt;
      FRAME_DONE <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench: two drivers (with and without blank phase) against a timeline reference model.
module tb_display_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  anode_a, anode_b;
  logic [6:0]  seg_a, seg_b;
  logic        fd_a, fd_b;

  int n_checks = 0;
  int n_pass   = 0;

  display_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(2), .CNT_W(8)) dut_a (
    .CLK(clk), .RST_N(rst_n), .EN(en), .LOAD(load), .DIGITS(digits),
    .ANODE(anode_a), .SEG(seg_a), .FRAME_DONE(fd_a));

  display_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(0), .CNT_W(8)) dut_b (
    .CLK(clk), .RST_N(rst_n), .EN(en), .LOAD(load), .DIGITS(digits),
    .ANODE(anode_b), .SEG(seg_b), .FRAME_DONE(fd_b));

  initial forever #5 clk = ~clk;

  typedef struct {
    bit          run;
    int          t;
    logic [15:0] active;
    logic [15:0] shadow;
    bit          pending;
  } mdl_t;

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010; seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
  end

  // Expected response packed as {anode, seg, frame_done}.
  task automatic model_step(input int s, input int b, input mdl_t mi,
                            output mdl_t mo, output logic [11:0] e);
    int  per, p, d;
    bit  nf;
    logic [15:0] up;
    mo = mi;
    e  = {4'hF, 7'h7F, 1'b0};
    nf = 0;
    if (!rst_n) begin
      mo = '{default: 0};
      return;
    end
    per = 4 * (s + b);
    if (!en) mo.run = 0;
    else if (!mi.run) begin mo.run = 1; mo.t = 0; nf = 1; end
    else begin mo.t = mi.t + 1; nf = (mo.t % per == 0); end
    if (nf) begin
      if (load) begin mo.active = digits; mo.shadow = digits; mo.pending = 0; end
      else if (mi.pending) begin mo.active = mi.shadow; mo.pending = 0; end
    end else if (load) begin
      mo.shadow = digits; mo.pending = 1;
    end
    if (mo.run) begin
      p = mo.t % per;
      d = p / (s + b);
      if (p % (s + b) < s) begin
        up = mo.active >> (4 * d);
        e[11:8] = ~(4'b0001 << d);
        e[7:1]  = seg_tab[up[3:0]];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        if (d != 0 && up == 16'h0000) e[11:1] = {4'hF, 7'h7F};
`endif
      end
      e[0] = nf && (mo.t != 0);
    end
  endtask

  function automatic void check(string name, logic [11:0] act, logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got anode=%b seg=%b fd=%b, expected anode=%b seg=%b fd=%b",
                  name, $time, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
  endfunction

  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};
  logic [11:0] q_a [$];
  logic [11:0] q_b [$];

  always @(posedge clk) begin
    mdl_t nxt;
    logic [11:0] e;
    model_step(4, 2, ma, nxt, e); ma = nxt; q_a.push_back(e);
    model_step(4, 0, mb, nxt, e); mb = nxt; q_b.push_back(e);
  end

  always @(negedge clk) begin
    if (q_a.size() > 0) check("scan_blank", {anode_a, seg_a, fd_a}, q_a.pop_front());
    if (q_b.size() > 0) check("scan_noblank", {anode_b, seg_b, fd_b}, q_b.pop_front());
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] mask;
    // Reset held with activity on EN and LOAD
    for (int k = 0; k < 6; k++) begin
      tick();
      en = 1'b1;
      load = 1'($urandom_range(0, 1));
      digits = 16'($urandom);
    end
    tick(); load = 1'b0; en = 1'b0; rst_n = 1'b1;
    tick(); tick();
    tick(); load = 1'b1; digits = 16'h1234;
    tick(); load = 1'b0; digits = 16'($urandom);
    tick(); en = 1'b1;
    // Mid-frame reload, load on frame transfer, disable in digit 2 blank, re-enable
    for (int k = 1; k <= 90; k++) begin
      tick();
      load = (k == 7) || (k == 24);
      digits = (k == 7) ? 16'hABCD : (k == 24) ? 16'h5678 : 16'($urandom);
      en = !(k >= 65 && k < 70);
    end
    load = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check("async_reset_a", {anode_a, seg_a, fd_a}, {4'hF, 7'h7F, 1'b0});
    check("async_reset_b", {anode_b, seg_b, fd_b}, {4'hF, 7'h7F, 1'b0});
    repeat (3) tick();
    load = 1'b1; digits = 16'h0008;
    tick(); rst_n = 1'b1; load = 1'b0;
    tick(); load = 1'b1; digits = 16'h0008;
    tick(); load = 1'b0;
    repeat (50) tick();
    load = 1'b1; digits = 16'h0070;
    tick(); load = 1'b0;
    repeat (60) tick();
    // Randomized operation, biased toward leading zeros
    for (int k = 0; k < 800; k++) begin
      tick();
      case ($urandom_range(0, 3))
        0: mask = 16'h000F;
        1: mask = 16'h00FF;
        2: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      digits = 16'($urandom) & mask;
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    load = 1'b0; en = 1'b1;
    repeat (30) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
